// File: rtl/cpu_pkg.sv
// cpu_pkg: shared states, opcodes, condition codes and instruction field positions.
package cpu_pkg;
  typedef enum logic [2:0] {FETCH, DECODE, EXECUTE, MEM, WRITEBACK, HALT, FAULT} state_t;
  localparam logic [3:0] OP_B = 4'hC, OP_LDR = 4'hD, OP_STR = 4'hE, OP_HALT = 4'hF;
  localparam logic [3:0] CC_EQ = 4'h0, CC_NE = 4'h1, CC_CS = 4'h2, CC_CC = 4'h3;
  localparam logic [3:0] CC_MI = 4'h4, CC_PL = 4'h5, CC_VS = 4'h6, CC_VC = 4'h7;
  localparam logic [3:0] CC_HI = 4'h8, CC_LS = 4'h9, CC_GE = 4'hA, CC_LT = 4'hB;
  localparam logic [3:0] CC_GT = 4'hC, CC_LE = 4'hD, CC_AL = 4'hE, CC_NV = 4'hF;
  localparam int N_BIT = 3, Z_BIT = 2, C_BIT = 1, V_BIT = 0;
  localparam int COND_HI = 31, COND_LO = 28, OP_HI = 27, OP_LO = 24, S_BIT = 23, IMM_HI = 18, IMM_LO = 3;
endpackage

// File: rtl/cond_check.sv
// cond_check: combinational ARM-style condition evaluation against NZCV.
module cond_check
  import cpu_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] nzcv,
  output logic       pass
);
  logic n, z, c, v;
  assign n = nzcv[N_BIT];
  assign z = nzcv[Z_BIT];
  assign c = nzcv[C_BIT];
  assign v = nzcv[V_BIT];
  always_comb begin
    pass = 1'b0;
    case (cond)
      CC_EQ: pass = z;
      CC_NE: pass = !z;
      CC_CS: pass = c;
      CC_CC: pass = !c;
      CC_MI: pass = n;
      CC_PL: pass = !n;
      CC_VS: pass = v;
      CC_VC: pass = !v;
      CC_HI: pass = c && !z;
      CC_LS: pass = !c || z;
      CC_GE: pass = n == v;
      CC_LT: pass = n != v;
      CC_GT: pass = !z && (n == v);
      CC_LE: pass = z || (n != v);
      CC_AL: pass = 1'b1;
      CC_NV: pass = 1'b0;
    endcase
  end
endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle FETCH/DECODE/EXECUTE/MEM/WRITEBACK control FSM owning PC and IR.
// Optional single-step mode with `define CPU_SEQ_SINGLE_STEP_EN (adds step input, idle output).
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int              PC_W        = 8,
  parameter logic [PC_W-1:0] RESET_PC    = '0,
  parameter int              MEM_TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     fetch_data,
  input  logic [3:0]      flags_in,
  input  logic            mem_ready,
  output logic [PC_W-1:0] pc,
  output logic [31:0]     ir,
  output logic            reg_we,
  output logic            flags_we,
  output logic            ram_en,
  output logic            ram_rw,
  output logic            ldr_sel,
  output logic            halted,
  output logic            fault
`ifdef CPU_SEQ_SINGLE_STEP_EN
  ,
  input  logic            step,
  output logic            idle
`endif
);
  localparam int TW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(MEM_TIMEOUT - 1);
  state_t state, state_n;
  logic [PC_W-1:0] pc_n;
  logic [31:0] ir_n;
  logic [TW-1:0] tmo, tmo_n;
  logic [3:0] op;
  logic pass, take;
  assign op = ir[OP_HI:OP_LO];
  cond_check u_cond (.cond(ir[COND_HI:COND_LO]), .nzcv(flags_in), .pass(pass));
`ifdef CPU_SEQ_SINGLE_STEP_EN
  logic step_q;
  assign take = step && !step_q;
  assign idle = state == FETCH && !take;
  always_ff @(posedge clk or posedge rst)
    if (rst) step_q <= 1'b0;
    else step_q <= step;
`else
  assign take = 1'b1;
`endif
  always_comb begin
    state_n = state;
    pc_n = pc;
    ir_n = ir;
    tmo_n = '0;
    case (state)
      FETCH: if (take) begin
        ir_n = fetch_data;
        state_n = DECODE;
      end
      DECODE: if (!pass) begin
        pc_n = pc + PC_W'(1);
        state_n = FETCH;
      end else if (op == OP_B) begin
        pc_n = PC_W'(ir[IMM_HI:IMM_LO]);
        state_n = FETCH;
      end else
        state_n = op == OP_HALT ? HALT : (op == OP_LDR || op == OP_STR) ? MEM : EXECUTE;
      EXECUTE: state_n = WRITEBACK;
      MEM: if (mem_ready) begin
        state_n = op == OP_STR ? FETCH : WRITEBACK;
        pc_n = op == OP_STR ? pc + PC_W'(1) : pc;
      end else if (tmo == TMO_LAST)
        state_n = FAULT;
      else
        tmo_n = tmo + TW'(1);
      WRITEBACK: begin
        pc_n = pc + PC_W'(1);
        state_n = FETCH;
      end
      default: ;
    endcase
  end
  // Strobes are registered from the next state so they align with the state they belong to.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= FETCH;
      pc <= RESET_PC;
      ir <= '0;
      tmo <= '0;
      reg_we <= 1'b0;
      flags_we <= 1'b0;
      ram_en <= 1'b0;
      ram_rw <= 1'b0;
      ldr_sel <= 1'b0;
      halted <= 1'b0;
      fault <= 1'b0;
    end else begin
      state <= state_n;
      pc <= pc_n;
      ir <= ir_n;
      tmo <= tmo_n;
      reg_we <= state_n == WRITEBACK;
      flags_we <= state_n == EXECUTE && ir_n[S_BIT];
      ram_en <= state_n == MEM;
      ram_rw <= state_n == MEM && ir_n[OP_HI:OP_LO] == OP_STR;
      ldr_sel <= state_n == WRITEBACK && ir_n[OP_HI:OP_LO] == OP_LDR;
      halted <= state_n == HALT || state_n == FAULT;
      fault <= state_n == FAULT;
    end
endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: directed checks of cpu_sequencer sequencing, PC, strobes, timeout and reset.
module tb_cpu_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] fetch_data = '0;
  logic [3:0] flags_in = '0;
  logic mem_ready = 1'b0;
  logic [7:0] pc;
  logic [31:0] ir;
  logic reg_we, flags_we, ram_en, ram_rw, ldr_sel, halted, fault;
  int n_cmp = 0, n_bad = 0;
`ifdef CPU_SEQ_SINGLE_STEP_EN
  logic step = 1'b0;
  logic idle;
`endif
  cpu_sequencer dut (
    .clk(clk), .rst(rst), .fetch_data(fetch_data), .flags_in(flags_in), .mem_ready(mem_ready),
    .pc(pc), .ir(ir), .reg_we(reg_we), .flags_we(flags_we), .ram_en(ram_en), .ram_rw(ram_rw),
    .ldr_sel(ldr_sel), .halted(halted), .fault(fault)
`ifdef CPU_SEQ_SINGLE_STEP_EN
    , .step(step), .idle(idle)
`endif
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic cyc();
    @(negedge clk);
  endtask
  function automatic logic [31:0] mk(input logic [3:0] cond, input logic [3:0] op, input logic s, input logic [15:0] imm);
    return {cond, op, s, 4'b0, imm, 3'b0};
  endfunction
  initial begin
    cyc();
    check("rst_pc", pc, 0);
    check("rst_ir", ir, 0);
    check("rst_strobes", {reg_we, flags_we, ram_en, ram_rw, ldr_sel}, 0);
    check("rst_halt_fault", {halted, fault}, 0);
    rst = 1'b0;
`ifdef CPU_SEQ_SINGLE_STEP_EN
    fetch_data = mk(4'hE, 4'h0, 1'b0, 16'h0);
    repeat (4) cyc();
    check("ss_wait_pc", pc, 0);
    check("ss_idle", idle, 1);
    for (int i = 0; i < 3; i++) begin
      step = 1'b1;
      cyc();
      step = 1'b0;
      repeat (5) cyc();
    end
    check("ss_retired", pc, 3);
    check("ss_idle_end", idle, 1);
    repeat (6) cyc();
    check("ss_no_extra", pc, 3);
`else
    fetch_data = mk(4'hE, 4'h0, 1'b1, 16'h0);
    cyc();
    check("alu_ir", ir, mk(4'hE, 4'h0, 1'b1, 16'h0));
    cyc();
    check("alu_fwe", flags_we, 1);
    check("alu_rwe_early", reg_we, 0);
    cyc();
    check("alu_rwe", reg_we, 1);
    check("alu_fwe_drop", flags_we, 0);
    check("alu_ldrsel", ldr_sel, 0);
    cyc();
    check("alu_pc", pc, 1);
    check("alu_rwe_drop", reg_we, 0);
    fetch_data = mk(4'h0, 4'h0, 1'b1, 16'h0);
    flags_in = 4'b0000;
    cyc();
    check("eq_fail_dec", {reg_we, flags_we}, 0);
    cyc();
    check("eq_fail_pc", pc, 2);
    check("eq_fail_strobes", {reg_we, flags_we}, 0);
    flags_in = 4'b0100;
    cyc();
    cyc();
    check("eq_pass_fwe", flags_we, 1);
    cyc();
    check("eq_pass_rwe", reg_we, 1);
    cyc();
    check("eq_pass_pc", pc, 3);
    fetch_data = mk(4'hE, 4'hD, 1'b0, 16'h0);
    flags_in = 4'b0000;
    cyc();
    cyc();
    for (int i = 0; i < 3; i++) begin
      check("ldr_en", ram_en, 1);
      check("ldr_rw", ram_rw, 0);
      check("ldr_no_rwe", reg_we, 0);
      if (i == 2) mem_ready = 1'b1;
      cyc();
    end
    mem_ready = 1'b0;
    check("ldr_en_drop", ram_en, 0);
    check("ldr_rwe", reg_we, 1);
    check("ldr_sel", ldr_sel, 1);
    cyc();
    check("ldr_pc", pc, 4);
    fetch_data = mk(4'hE, 4'hE, 1'b0, 16'h0);
    cyc();
    cyc();
    check("str_en", ram_en, 1);
    check("str_rw", ram_rw, 1);
    mem_ready = 1'b1;
    cyc();
    mem_ready = 1'b0;
    check("str_en_drop", ram_en, 0);
    check("str_no_rwe", reg_we, 0);
    check("str_pc", pc, 5);
    fetch_data = mk(4'hE, 4'hC, 1'b0, 16'h0042);
    cyc();
    check("b_dec_pc", pc, 5);
    cyc();
    check("b_pc", pc, 8'h42);
    fetch_data = mk(4'hE, 4'hC, 1'b0, 16'h00FF);
    cyc();
    cyc();
    check("b_ff_pc", pc, 8'hFF);
    fetch_data = mk(4'hF, 4'h0, 1'b0, 16'h0);
    mem_ready = 1'b1;
    cyc();
    cyc();
    mem_ready = 1'b0;
    check("wrap_pc", pc, 8'h00);
    check("nv_no_rwe", reg_we, 0);
    fetch_data = mk(4'hE, 4'hE, 1'b0, 16'h0);
    cyc();
    cyc();
    repeat (14) cyc();
    check("tmo_still_mem", ram_en, 1);
    check("tmo_no_fault", fault, 0);
    cyc();
    check("tmo_fault", fault, 1);
    check("tmo_halted", halted, 1);
    check("tmo_en_drop", ram_en, 0);
    repeat (3) cyc();
    check("fault_sticky", fault, 1);
    check("fault_pc", pc, 0);
    rst = 1'b1;
    #1;
    check("rst_clears_fault", {halted, fault}, 0);
    cyc();
    rst = 1'b0;
    fetch_data = mk(4'hE, 4'hC, 1'b0, 16'h0010);
    cyc();
    cyc();
    check("b10_pc", pc, 8'h10);
    fetch_data = mk(4'hE, 4'hE, 1'b0, 16'h0);
    cyc();
    cyc();
    check("mid_mem_en", ram_en, 1);
    #2 rst = 1'b1;
    #1;
    check("async_en", ram_en, 0);
    check("async_pc", pc, 0);
    cyc();
    rst = 1'b0;
    fetch_data = mk(4'hF, 4'hF, 1'b0, 16'h0);
    cyc();
    cyc();
    check("nv_halt_pc", pc, 1);
    check("nv_halt_run", halted, 0);
    fetch_data = mk(4'hE, 4'hF, 1'b0, 16'h0);
    cyc();
    cyc();
    check("halt_on", halted, 1);
    check("halt_no_fault", fault, 0);
    repeat (3) cyc();
    check("halt_sticky", halted, 1);
    check("halt_pc_frozen", pc, 1);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
- Multi-cycle control FSM for the 32-bit processor datapath.
- Owns the PC and the instruction register (IR), and sequences FETCH/DECODE/EXECUTE/MEM/WRITEBACK.
- Gates RegisterBank writes, FlagsReg updates and RAM read/write on the instruction's condition field evaluated against NZCV.
- Sits between Ram (fetch port, data port) and the ALU/RegisterBank/MemoryControlSystem.

Parameters:
- PC_W, 8, program counter width; fetch address is zero-extended to 16 bits.
- RESET_PC, 0, PC value after reset.
- MEM_TIMEOUT, 15, max cycles waiting for mem_ready before entering FAULT.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- fetch_data  in  32  instruction word from Ram fetch_out.
- flags_in  in  4  NZCV from FlagsReg, {N,Z,C,V}.
- mem_ready  in  1  Ram data-port access complete; high for one cycle.
- pc  out  PC_W  current fetch address.
- ir  out  32  latched instruction driving the field split.
- reg_we  out  1  RegisterBank write strobe, one cycle.
- flags_we  out  1  FlagsReg update strobe, one cycle.
- ram_en  out  1  data-port access request, held until mem_ready.
- ram_rw  out  1  1 = write (STR), 0 = read (LDR); valid while ram_en is high.
- ldr_sel  out  1  Din mux: 1 = RAM data, 0 = ALU result.
- halted  out  1  in HALT or FAULT.
- fault  out  1  in FAULT (memory timeout).

Behaviour:
- Reset (async):
  - state = FETCH, pc = RESET_PC, ir = 0.
  - All strobes (reg_we, flags_we, ram_en, ram_rw, ldr_sel) = 0; halted = 0, fault = 0; timeout counter = 0.
- Opcode classes, from ir[27:24]:
  - 0x0-0xB: ALU op.
  - 0xC: B (absolute branch, target = ir[18:3] truncated to PC_W).
  - 0xD: LDR.
  - 0xE: STR.
  - 0xF: HALT.
- Condition pass, from ir[31:28], ARM order:
  - 0 EQ Z, 1 NE !Z, 2 CS C, 3 CC !C, 4 MI N, 5 PL !N, 6 VS V, 7 VC !V.
  - 8 HI C&!Z, 9 LS !C|Z, A GE N==V, B LT N!=V, C GT !Z&(N==V), D LE Z|(N!=V).
  - E AL = 1, F NV = 0.
- States:
  - FETCH (1 cycle): ir <= fetch_data -> DECODE.
  - DECODE (1 cycle): evaluate cond on flags_in.
    - Fail -> pc <= pc+1, go to FETCH; no strobes. This includes HALT with a failing cond.
    - Pass: ALU -> EXECUTE; LDR/STR -> MEM; B -> pc <= target, go to FETCH; HALT -> HALT, pc unchanged.
  - EXECUTE (1 cycle): flags_we = ir[23] (s_bit); ldr_sel = 0 -> WRITEBACK.
  - MEM:
    - ram_en = 1; ram_rw = (op==STR).
    - Wait for mem_ready. Timeout counter increments each cycle with no mem_ready.
    - mem_ready -> LDR: WRITEBACK with ldr_sel = 1; STR: pc <= pc+1, go to FETCH.
    - Counter reaches MEM_TIMEOUT -> FAULT.
    - ram_en drops in the cycle after mem_ready.
  - WRITEBACK (1 cycle): reg_we = 1; pc <= pc+1 -> FETCH.
  - HALT: sticky; only rst exits.
  - FAULT: sticky; fault = 1; only rst exits.
- Latency:
  - ALU op 4 cycles.
  - LDR 4 + wait cycles (min 1).
  - STR 3 + wait.
  - B 2.
  - Failed cond 2.
- PC arithmetic: wraps modulo 2^PC_W (0xFF+1 = 0x00, no fault).
- Flags: flags_in is sampled only in DECODE. A flags_we in instruction N is visible to instruction N+1.
- mem_ready arriving outside MEM is ignored.
- Reset mid-MEM: ram_en drops immediately (async). No write is guaranteed to have completed.
- Strobes are registered outputs, glitch-free, decoded from state.

Optional Feature:
- Macro: CPU_SEQ_SINGLE_STEP_EN.
- When defined:
  - Adds input step (1 bit).
  - FETCH waits until step = 1; a rising-edge detect consumes exactly one instruction per pulse.
  - Adds output idle (1 bit), high while FETCH is waiting.
- When undefined: FETCH never waits. No step or idle ports exist.

Decomposition:
- Package cpu_pkg holds:
  - State enum: FETCH, DECODE, EXECUTE, MEM, WRITEBACK, HALT, FAULT.
  - Opcode constants: OP_B = 4'hC, OP_LDR = 4'hD, OP_STR = 4'hE, OP_HALT = 4'hF.
  - Condition-code constants; NZCV bit indices.
  - Instruction field bit positions: cond[31:28], op[27:24], s[23], imm[18:3].
- One sub-module: cond_check, combinational (cond, nzcv) -> pass. It is reused later by a pipelined core.

Test Plan:
- ALU op, cond AL (0xE), s = 1, at pc 0x00 -> flags_we = 1 in cycle 3; reg_we = 1 in cycle 4; pc = 0x01 at the next FETCH.
- EQ ALU op with flags_in = 4'b0000 -> no reg_we or flags_we; pc advances after 2 cycles. Repeat with Z = 1 -> executes.
- LDR, mem_ready after 3 cycles -> ram_en = 1 and ram_rw = 0 for 3 cycles; then ldr_sel = 1 with reg_we. STR -> ram_rw = 1, no reg_we.
- B with imm 0x0042 -> pc = 0x42 two cycles after FETCH. Plain increment from pc = 0xFF -> 0x00.
- STR with mem_ready never asserted -> FAULT after 15 wait cycles; fault = halted = 1. Async rst mid-MEM -> pc = 0, ram_en = 0 without waiting for a clock edge.
- HALT with cond AL -> halted = 1, pc frozen. With CPU_SEQ_SINGLE_STEP_EN, 3 step pulses -> exactly 3 instructions retired.
